// File: rtl/burst_write_arbiter.sv
// burst_write_arbiter: two-requester burst-granular round-robin arbiter with per-burst response routing
module burst_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RESP_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s0_addr,
  input  logic [7:0]            s0_length,
  input  logic                  s0_addr_valid,
  output logic                  s0_addr_ready,
  input  logic [DATA_WIDTH-1:0] s0_data,
  input  logic                  s0_data_valid,
  output logic                  s0_data_ready,
  output logic [ADDR_WIDTH-1:0] s0_resp,
  output logic                  s0_resp_valid,
  input  logic                  s0_resp_ready,
  input  logic [ADDR_WIDTH-1:0] s1_addr,
  input  logic [7:0]            s1_length,
  input  logic                  s1_addr_valid,
  output logic                  s1_addr_ready,
  input  logic [DATA_WIDTH-1:0] s1_data,
  input  logic                  s1_data_valid,
  output logic                  s1_data_ready,
  output logic [ADDR_WIDTH-1:0] s1_resp,
  output logic                  s1_resp_valid,
  input  logic                  s1_resp_ready,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [7:0]            m_length,
  output logic                  m_addr_valid,
  input  logic                  m_addr_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_data_valid,
  input  logic                  m_data_ready,
  input  logic [ADDR_WIDTH-1:0] m_resp,
  input  logic                  m_resp_valid,
  output logic                  m_resp_ready,
  output logic                  busy,
  output logic                  grant_id,
  output logic                  err_unexpected
);
  localparam int PW = $clog2(RESP_DEPTH);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;
  state_e state_q, state_d;
  logic grant_q, grant_d, prio_q, prio_d, err_q;
  logic [7:0] cnt_q, cnt_d, rcnt_q;
  logic [8:0] fifo_q [RESP_DEPTH];
  logic [PW:0] wp_q, rp_q;
  logic [8:0] head;
  logic in_addr, in_data, empty, full, ahs, dhs, rhs, pop, hid;
  assign in_addr = state_q == ADDR;
  assign in_data = state_q == DATA;
  assign empty = wp_q == rp_q;
  assign full = (wp_q[PW] != rp_q[PW]) && (wp_q[PW-1:0] == rp_q[PW-1:0]);
  assign head = fifo_q[rp_q[PW-1:0]];
  assign hid = head[8];
  assign m_addr = in_addr ? (grant_q ? s1_addr : s0_addr) : '0;
  assign m_length = in_addr ? (grant_q ? s1_length : s0_length) : '0;
  assign m_addr_valid = in_addr && (grant_q ? s1_addr_valid : s0_addr_valid);
  assign s0_addr_ready = in_addr && !grant_q && m_addr_ready;
  assign s1_addr_ready = in_addr && grant_q && m_addr_ready;
  assign m_data = in_data ? (grant_q ? s1_data : s0_data) : '0;
  assign m_data_valid = in_data && (grant_q ? s1_data_valid : s0_data_valid);
  assign s0_data_ready = in_data && !grant_q && m_data_ready;
  assign s1_data_ready = in_data && grant_q && m_data_ready;
  assign ahs = m_addr_valid && m_addr_ready;
  assign dhs = m_data_valid && m_data_ready;
  // Responses go to whichever requester owns the oldest outstanding burst
  assign s0_resp = m_resp;
  assign s1_resp = m_resp;
  assign s0_resp_valid = !empty && !hid && m_resp_valid;
  assign s1_resp_valid = !empty && hid && m_resp_valid;
  assign m_resp_ready = empty ? 1'b1 : (hid ? s1_resp_ready : s0_resp_ready);
  assign rhs = m_resp_valid && m_resp_ready && !empty;
  assign pop = rhs && (rcnt_q == head[7:0]);
  assign busy = state_q != IDLE;
  assign grant_id = grant_q;
  assign err_unexpected = err_q;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    prio_d = prio_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (!full && (s0_addr_valid || s1_addr_valid)) begin
        grant_d = (s0_addr_valid && s1_addr_valid) ? prio_q : s1_addr_valid;
        state_d = ADDR;
      end
      ADDR: if (ahs) begin
        cnt_d = m_length;
        state_d = DATA;
      end
      DATA: if (dhs) begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
          prio_d = !grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      prio_q <= 1'b0;
      cnt_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      rcnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      prio_q <= prio_d;
      cnt_q <= cnt_d;
      wp_q <= ahs ? wp_q + 1'b1 : wp_q;
      rp_q <= pop ? rp_q + 1'b1 : rp_q;
      rcnt_q <= pop ? 8'd0 : (rhs ? rcnt_q + 8'd1 : rcnt_q);
      err_q <= err_q || (empty && m_resp_valid);
    end
  end
  always_ff @(posedge clk) begin
    if (ahs) fifo_q[wp_q[PW-1:0]] <= {grant_q, m_length};
  end
endmodule

// File: tb/tb_burst_write_arbiter.sv
// tb_burst_write_arbiter: directed bursts against a queue-based model of grants, beats and response routing
module tb_burst_write_arbiter;
  localparam int DEPTH = 4;
  typedef struct { logic [31:0] addr; logic [7:0] len; } burst_t;
  typedef struct { bit id; int n; } route_t;
  logic clk = 0, rst_n = 0;
  logic [31:0] s0_addr = 0, s1_addr = 0, s0_data = 0, s1_data = 0, s0_resp, s1_resp;
  logic [7:0] s0_length = 0, s1_length = 0, m_length;
  logic s0_addr_valid = 0, s1_addr_valid = 0, s0_addr_ready, s1_addr_ready;
  logic s0_data_valid = 0, s1_data_valid = 0, s0_data_ready, s1_data_ready;
  logic s0_resp_valid, s1_resp_valid, s0_resp_ready = 1, s1_resp_ready = 1;
  logic [31:0] m_addr, m_data, m_resp = 0;
  logic m_addr_valid, m_addr_ready = 1, m_data_valid, m_data_ready = 1;
  logic m_resp_valid = 0, m_resp_ready, busy, grant_id, err_unexpected;
  int checks = 0, failures = 0;
  burst_t bq0[$], bq1[$];
  route_t rq[$];
  int ph = 0, bl = 0, idx = 0, nb = 0, na = 0, nrs0 = 0, nrs1 = 0;
  bit ag = 0, prio = 0, err_m = 0;
  logic [31:0] cur_addr = 0, la = 0, resp_val = 32'hA000_0000;
  logic [7:0] ll = 0;
  bit gl[$];
  bit gap_en = 0, rdy_rand = 0, resp_en = 1, force_unexp = 0, rr0 = 1, rr1 = 1;

  burst_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RESP_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_addr(s0_addr), .s0_length(s0_length), .s0_addr_valid(s0_addr_valid), .s0_addr_ready(s0_addr_ready),
    .s0_data(s0_data), .s0_data_valid(s0_data_valid), .s0_data_ready(s0_data_ready),
    .s0_resp(s0_resp), .s0_resp_valid(s0_resp_valid), .s0_resp_ready(s0_resp_ready),
    .s1_addr(s1_addr), .s1_length(s1_length), .s1_addr_valid(s1_addr_valid), .s1_addr_ready(s1_addr_ready),
    .s1_data(s1_data), .s1_data_valid(s1_data_valid), .s1_data_ready(s1_data_ready),
    .s1_resp(s1_resp), .s1_resp_valid(s1_resp_valid), .s1_resp_ready(s1_resp_ready),
    .m_addr(m_addr), .m_length(m_length), .m_addr_valid(m_addr_valid), .m_addr_ready(m_addr_ready),
    .m_data(m_data), .m_data_valid(m_data_valid), .m_data_ready(m_data_ready),
    .m_resp(m_resp), .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready),
    .busy(busy), .grant_id(grant_id), .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, a, e, $time);
    end
  endtask

  function automatic bit is_idle();
    return bq0.size() == 0 && bq1.size() == 0 && ph == 0 && rq.size() == 0;
  endfunction

  task automatic clear_stats();
    nb = 0; na = 0; nrs0 = 0; nrs1 = 0; gl.delete();
  endtask

  // One clock: drive inputs at negedge, check the model's view at negedge+1, then advance the model
  task automatic cycle();
    burst_t h;
    route_t r;
    bit own0, own1, v0, v1, exp_av, exp_dv, emp, hid, mrr, full, ahs, dhs, rhs;
    @(negedge clk);
    v0 = bq0.size() != 0;
    v1 = bq1.size() != 0;
    own0 = ph == 2 && !ag;
    own1 = ph == 2 && ag;
    s0_addr_valid = v0; s0_addr = v0 ? bq0[0].addr : 32'h0; s0_length = v0 ? bq0[0].len : 8'h0;
    s1_addr_valid = v1; s1_addr = v1 ? bq1[0].addr : 32'h0; s1_length = v1 ? bq1[0].len : 8'h0;
    s0_data_valid = own0 ? (gap_en ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b1;
    s0_data = own0 ? cur_addr + 32'(idx) : 32'hBAD0_0000;
    s1_data_valid = own1 ? (gap_en ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b1;
    s1_data = own1 ? cur_addr + 32'(idx) : 32'hBAD1_0000;
    m_addr_ready = 1'b1;
    m_data_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    m_resp_valid = force_unexp || (resp_en && rq.size() > 0);
    m_resp = resp_val;
    s0_resp_ready = rr0; s1_resp_ready = rr1;
    #1;
    exp_av = ph == 1;
    exp_dv = ph == 2 && (ag ? s1_data_valid : s0_data_valid);
    emp = rq.size() == 0;
    hid = emp ? 1'b0 : rq[0].id;
    mrr = emp ? 1'b1 : (hid ? rr1 : rr0);
    chk("m_addr_valid", m_addr_valid, exp_av);
    chk("s0_addr_ready", s0_addr_ready, exp_av && !ag && m_addr_ready);
    chk("s1_addr_ready", s1_addr_ready, exp_av && ag && m_addr_ready);
    if (exp_av) begin
      h = ag ? bq1[0] : bq0[0];
      chk("m_addr", m_addr, h.addr);
      chk("m_length", m_length, h.len);
    end
    chk("m_data_valid", m_data_valid, exp_dv);
    if (exp_dv) chk("m_data", m_data, cur_addr + 32'(idx));
    chk("s0_data_ready", s0_data_ready, ph == 2 && !ag && m_data_ready);
    chk("s1_data_ready", s1_data_ready, ph == 2 && ag && m_data_ready);
    chk("busy", busy, ph != 0);
    chk("grant_id", grant_id, ag);
    chk("err_unexpected", err_unexpected, err_m);
    chk("s0_resp_valid", s0_resp_valid, !emp && !hid && m_resp_valid);
    chk("s1_resp_valid", s1_resp_valid, !emp && hid && m_resp_valid);
    chk("m_resp_ready", m_resp_ready, mrr);
    if (s0_resp_valid) chk("s0_resp", s0_resp, resp_val);
    if (s1_resp_valid) chk("s1_resp", s1_resp, resp_val);
    ahs = exp_av && m_addr_ready;
    dhs = exp_dv && m_data_ready;
    rhs = m_resp_valid && mrr;
    full = rq.size() == DEPTH;
    if (rhs) begin
      if (emp) err_m = 1;
      else begin
        if (hid) nrs1++; else nrs0++;
        r = rq[0]; r.n--; rq[0] = r;
        if (r.n == 0) void'(rq.pop_front());
      end
      resp_val++;
    end
    case (ph)
      0: if (!full && (v0 || v1)) begin ag = (v0 && v1) ? prio : v1; ph = 1; end
      1: if (ahs) begin
        h = ag ? bq1.pop_front() : bq0.pop_front();
        la = m_addr; ll = m_length; gl.push_back(grant_id); na++;
        cur_addr = h.addr; idx = 0; bl = int'(h.len) + 1;
        rq.push_back('{id: ag, n: bl});
        ph = 2;
      end
      default: if (dhs) begin
        idx++; nb++; bl--;
        if (bl == 0) begin ph = 0; prio = !ag; end
      end
    endcase
  endtask

  task automatic run_idle(input int maxc);
    int n = 0;
    do begin cycle(); n++; end while (!is_idle() && n < maxc);
    chk("idle_within_budget", is_idle(), 1);
  endtask

  // Reset lands mid low-phase so its immediate effect is visible before any clock edge
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 0;
    m_resp_valid = 0;
    force_unexp = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_err", err_unexpected, 0);
    chk("rst_m_addr_valid", m_addr_valid, 0);
    chk("rst_m_data_valid", m_data_valid, 0);
    chk("rst_ready", {s0_addr_ready, s1_addr_ready, s0_data_ready, s1_data_ready}, 0);
    chk("rst_resp_valid", {s0_resp_valid, s1_resp_valid}, 0);
    chk("rst_m_resp_ready", m_resp_ready, 1);
    s0_addr_valid = 0; s1_addr_valid = 0; s0_data_valid = 0; s1_data_valid = 0;
    bq0.delete(); bq1.delete(); rq.delete();
    ph = 0; bl = 0; idx = 0; ag = 0; prio = 0; err_m = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    do_reset();
    // single s0 burst
    clear_stats();
    bq0.push_back('{addr: 32'h100, len: 8'd3});
    run_idle(60);
    chk("t1_addr", la, 32'h100);
    chk("t1_len", ll, 3);
    chk("t1_beats", nb, 4);
    chk("t1_grant", gl.size() == 1 ? gl[0] : 1'bx, 0);
    chk("t1_resp_s0", nrs0, 4);
    chk("t1_resp_s1", nrs1, 0);
    // both request from reset: round-robin 0,1,0,1
    do_reset();
    clear_stats();
    bq0.push_back('{addr: 32'h200, len: 8'd1}); bq0.push_back('{addr: 32'h220, len: 8'd1});
    bq1.push_back('{addr: 32'h300, len: 8'd1}); bq1.push_back('{addr: 32'h320, len: 8'd1});
    run_idle(120);
    chk("t2_ngrants", gl.size(), 4);
    if (gl.size() == 4) chk("t2_order", {gl[0], gl[1], gl[2], gl[3]}, 4'b0101);
    chk("t2_beats", nb, 8);
    // len 0 on s1
    clear_stats();
    bq1.push_back('{addr: 32'h400, len: 8'd0});
    run_idle(40);
    chk("t3_beats", nb, 1);
    chk("t3_grant", gl.size() == 1 ? gl[0] : 1'bx, 1);
    chk("t3_resp_s1", nrs1, 1);
    chk("t3_resp_s0", nrs0, 0);
    // routing FIFO full blocks the fifth grant
    clear_stats();
    rr0 = 0;
    for (int i = 0; i < 5; i++) bq0.push_back('{addr: 32'h1000 + 32'(i * 16), len: 8'd0});
    repeat (40) cycle();
    chk("t4_accepted_while_full", na, 4);
    chk("t4_outstanding", rq.size(), 4);
    chk("t4_blocked_addr_valid", m_addr_valid, 0);
    rr0 = 1;
    run_idle(60);
    chk("t4_accepted_total", na, 5);
    chk("t4_resp_s0", nrs0, 5);
    // stalls on both sides of the data path
    clear_stats();
    gap_en = 1; rdy_rand = 1;
    bq0.push_back('{addr: 32'h500, len: 8'd7});
    run_idle(200);
    chk("t5_beats", nb, 8);
    chk("t5_resp_s0", nrs0, 8);
    gap_en = 0; rdy_rand = 0;
    // reset mid-burst, then s1 alone
    clear_stats();
    resp_en = 0;
    bq0.push_back('{addr: 32'h600, len: 8'd3});
    for (int i = 0; i < 40 && nb < 2; i++) cycle();
    chk("t6_beats_before_reset", nb, 2);
    do_reset();
    resp_en = 1;
    clear_stats();
    bq1.push_back('{addr: 32'h700, len: 8'd0});
    run_idle(40);
    chk("t6_grant_s1", gl.size() == 1 ? gl[0] : 1'bx, 1);
    chk("t6_resp_s1", nrs1, 1);
    // unexpected response with empty routing FIFO
    force_unexp = 1;
    cycle();
    force_unexp = 0;
    repeat (3) cycle();
    chk("t6_err_sticky", err_unexpected, 1);
    do_reset();
    cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end
endmodule
